// File: rtl/run_length_compressor.sv
// run_length_compressor: bit-serial run-length encoder.
// Consumes N-bit words LSB-first and emits (bit, run-length) tokens.
// Runs merge across word boundaries. A flush emits the final partial run.
// Optional statistics counters are enabled by defining RLC_STATS_EN.
module run_length_compressor #(
  parameter int unsigned N = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_bit,
  output logic [$clog2(N):0]   out_value,
  output logic [15:0]          tok_count,
  output logic [15:0]          bit_count
);

  localparam int unsigned LW = $clog2(N) + 1;
  localparam int unsigned IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_shreg;
  logic [N-1:0]    w_shreg_nxt;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx_nxt;
  logic [LW-1:0]   r_run_len;
  logic [LW-1:0]   w_run_len_nxt;
  logic            r_run_bit;
  logic            w_run_bit_nxt;
  logic            r_in_ready;
  logic            w_in_ready_nxt;
  logic            r_out_valid;
  logic            w_out_valid_nxt;
  logic            r_out_bit;
  logic            w_out_bit_nxt;
  logic [LW-1:0]   r_out_value;
  logic [LW-1:0]   w_out_value_nxt;
  logic            w_stall;
  logic            w_load;
  logic            w_scan_bit;

  // The output slot is occupied and not being drained this cycle.
  assign w_stall    = r_out_valid && !out_ready;
  assign w_scan_bit = r_shreg[0];

  // State register and all datapath/output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_idx       <= '0;
      r_run_len   <= '0;
      r_run_bit   <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_value <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_shreg     <= w_shreg_nxt;
      r_idx       <= w_idx_nxt;
      r_run_len   <= w_run_len_nxt;
      r_run_bit   <= w_run_bit_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_bit   <= w_out_bit_nxt;
      r_out_value <= w_out_value_nxt;
    end
  end

  // Next-state, run tracking and token-slot logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_shreg_nxt     = r_shreg;
    w_idx_nxt       = r_idx;
    w_run_len_nxt   = r_run_len;
    w_run_bit_nxt   = r_run_bit;
    w_load          = 1'b0;

    unique case (r_state)
      IDLE: begin
        // in_ready is low for the first cycle after reset; nothing is taken then.
        if (r_in_ready) begin
          if (in_valid) begin
            w_shreg_nxt = in_data;
            w_idx_nxt   = '0;
            w_state_nxt = SCAN;
          end else if (flush && (r_run_len != '0)) begin
            w_state_nxt = FLUSH;
          end
        end
      end

      SCAN: begin
        if (!w_stall) begin
          if (r_run_len == '0) begin
            w_run_bit_nxt = w_scan_bit;
            w_run_len_nxt = LW'(1);
          end else if ((w_scan_bit == r_run_bit) && (r_run_len < LW'(N))) begin
            w_run_len_nxt = r_run_len + LW'(1);
          end else begin
            // Bit change or full-length run: emit the current run, start a new one.
            w_load        = 1'b1;
            w_run_bit_nxt = w_scan_bit;
            w_run_len_nxt = LW'(1);
          end
          w_shreg_nxt = r_shreg >> 1;
          if (r_idx == IW'(N - 1)) begin
            w_idx_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
      end

      FLUSH: begin
        if (!w_stall) begin
          w_load        = 1'b1;
          w_run_len_nxt = '0;
          w_state_nxt   = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_in_ready_nxt  = (w_state_nxt == IDLE);

    // One-entry token slot: load wins over drain, so there is no bubble.
    w_out_valid_nxt = r_out_valid;
    w_out_bit_nxt   = r_out_bit;
    w_out_value_nxt = r_out_value;
    if (w_load) begin
      w_out_valid_nxt = 1'b1;
      w_out_bit_nxt   = r_run_bit;
      w_out_value_nxt = r_run_len;
    end else if (out_ready) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign out_value = r_out_value;

`ifdef RLC_STATS_EN
  logic [15:0] r_tok_count;
  logic [15:0] r_bit_count;
  logic        w_bit_adv;

  assign w_bit_adv = (r_state == SCAN) && !w_stall;

  // Token handshake and scanned-bit counters, wrapping mod 2^16.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tok_count <= '0;
      r_bit_count <= '0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_tok_count <= r_tok_count + 16'd1;
      end
      if (w_bit_adv) begin
        r_bit_count <= r_bit_count + 16'd1;
      end
    end
  end

  assign tok_count = r_tok_count;
  assign bit_count = r_bit_count;
`else
  assign tok_count = 16'd0;
  assign bit_count = 16'd0;
`endif

endmodule
